// File: rtl/clock_pkg.sv
// Shared types and constants for the 24h BCD clock: digit type, field limits,
// key indices and the set-sequencer state encoding.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t HOUR_MAX_H = 4'd2;
    localparam bcd_t HOUR_MAX_L = 4'd3;
    localparam bcd_t MIN_MAX_H  = 4'd5;
    localparam bcd_t MIN_MAX_L  = 4'd9;

    localparam int K_HA     = 0;
    localparam int K_HD     = 1;
    localparam int K_MA     = 2;
    localparam int K_MD     = 3;
    localparam int NUM_KEYS = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRST    = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } set_state_e;

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: 2-FF synchroniser followed by a ms-tick debounce counter.
// The accepted level only moves after the synced level has disagreed with it for
// DEBOUNCE_MS consecutive ticks.
module key_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic key_i,
    output logic key_o
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            key_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], key_i};
            // Any reversal (synced level back to accepted level) restarts the count.
            if (sync_q[1] == key_q) begin
                cnt_q <= '0;
            end else if (tick_i) begin
                if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
                    key_q <= sync_q[1];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign key_o = key_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer for the BCD clock core: debounces the four set keys, issues
// single and auto-repeat steps, and hands the stepped time to the core as load/value.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ          = 12_000_000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 600,
    parameter int REPEAT_RATE_MS  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hour_a,
    input  logic       hour_d,
    input  logic       min_a,
    input  logic       min_d,
    input  logic [3:0] cur_hour_high,
    input  logic [3:0] cur_hour_low,
    input  logic [3:0] cur_min_high,
    input  logic [3:0] cur_min_low,
    output logic       load,
    output logic [3:0] load_hour_high,
    output logic [3:0] load_hour_low,
    output logic [3:0] load_min_high,
    output logic [3:0] load_min_low,
    output logic       editing
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TW       = $clog2(TICK_DIV + 1);
    localparam int RMAX     = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RW       = $clog2(RMAX + 1);
    localparam logic [4:0] H_TOP = 5'(int'(HOUR_MAX_H) * 10 + int'(HOUR_MAX_L));
    localparam logic [5:0] M_TOP = 6'(int'(MIN_MAX_H) * 10 + int'(MIN_MAX_L));

    // ---------------- 1 ms tick ----------------
    logic [TW-1:0] tick_cnt_q;
    logic          tick;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end

    // ---------------- key conditioning ----------------
    logic [NUM_KEYS-1:0] key_raw, key_db, key_prev_q, key_fall;

    assign key_raw[K_HA] = hour_a;
    assign key_raw[K_HD] = hour_d;
    assign key_raw[K_MA] = min_a;
    assign key_raw[K_MD] = min_d;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick_i (tick),
            .key_i  (key_raw[g]),
            .key_o  (key_db[g])
        );
    end

    assign key_fall = key_prev_q & ~key_db;

    // ---------------- FSM state and key selection ----------------
    set_state_e    state_q;
    logic [1:0]    sel_q, sel_d;
    logic [RW-1:0] rep_cnt_q;
    logic          step_pend_q;
    logic          sel_held, any_held, step;

    assign sel_held = ~key_db[sel_q];
    assign any_held = ~&key_db;

    always_comb begin
        sel_d = 2'(K_MD);
        if      (key_fall[K_HA]) sel_d = 2'(K_HA);
        else if (key_fall[K_HD]) sel_d = 2'(K_HD);
        else if (key_fall[K_MA]) sel_d = 2'(K_MA);
    end

    always_comb begin
        step = 1'b0;
        case (state_q)
            ST_FIRST:  step = step_pend_q | (sel_held & tick & (rep_cnt_q == RW'(REPEAT_DELAY_MS - 1)));
            ST_REPEAT: step = sel_held & tick & (rep_cnt_q == RW'(REPEAT_RATE_MS - 1));
            default:   step = 1'b0;
        endcase
    end

    // ---------------- BCD step ----------------
    logic       hour_ok, min_ok;
    logic [4:0] hbin, hbin_d;
    logic [5:0] mbin, mbin_d;
    bcd_t       ld_hh_d, ld_hl_d, ld_mh_d, ld_ml_d;

    always_comb begin
        hour_ok = ((cur_hour_high < HOUR_MAX_H) && (cur_hour_low <= 4'd9)) ||
                  ((cur_hour_high == HOUR_MAX_H) && (cur_hour_low <= HOUR_MAX_L));
        min_ok  = (cur_min_high <= MIN_MAX_H) && (cur_min_low <= MIN_MAX_L);
        // Out-of-range fields collapse to 00 before stepping.
        hbin    = hour_ok ? 5'(cur_hour_high) * 5'd10 + 5'(cur_hour_low) : 5'd0;
        mbin    = min_ok  ? 6'(cur_min_high) * 6'd10 + 6'(cur_min_low)   : 6'd0;
        hbin_d  = hbin;
        mbin_d  = mbin;
        case (sel_q)
            2'(K_HA): hbin_d = (hbin == H_TOP) ? 5'd0 : hbin + 5'd1;
            2'(K_HD): hbin_d = (hbin == 5'd0)  ? H_TOP : hbin - 5'd1;
            2'(K_MA): mbin_d = (mbin == M_TOP) ? 6'd0 : mbin + 6'd1;
            default:  mbin_d = (mbin == 6'd0)  ? M_TOP : mbin - 6'd1;
        endcase
        ld_hh_d = bcd_t'(hbin_d / 5'd10);
        ld_hl_d = bcd_t'(hbin_d % 5'd10);
        ld_mh_d = bcd_t'(mbin_d / 6'd10);
        ld_ml_d = bcd_t'(mbin_d % 6'd10);
    end

    // ---------------- sequencer and registered outputs ----------------
    logic load_q, editing_q;
    bcd_t ld_hh_q, ld_hl_q, ld_mh_q, ld_ml_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            rep_cnt_q   <= '0;
            step_pend_q <= 1'b0;
            key_prev_q  <= '1;
            load_q      <= 1'b0;
            ld_hh_q     <= '0;
            ld_hl_q     <= '0;
            ld_mh_q     <= '0;
            ld_ml_q     <= '0;
            editing_q   <= 1'b0;
        end else begin
            key_prev_q <= key_db;
            editing_q  <= any_held;
            load_q     <= step;
            if (step) begin
                ld_hh_q <= ld_hh_d;
                ld_hl_q <= ld_hl_d;
                ld_mh_q <= ld_mh_d;
                ld_ml_q <= ld_ml_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|key_fall) begin
                        sel_q       <= sel_d;
                        rep_cnt_q   <= '0;
                        step_pend_q <= 1'b1;
                        state_q     <= ST_FIRST;
                    end
                end
                ST_FIRST: begin
                    step_pend_q <= 1'b0;
                    if (!step_pend_q && !sel_held) begin
                        state_q <= ST_IDLE;
                    end else if (tick) begin
                        if (rep_cnt_q == RW'(REPEAT_DELAY_MS - 1)) begin
                            rep_cnt_q <= '0;
                            state_q   <= ST_REPEAT;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!sel_held) begin
                        state_q <= any_held ? ST_WAIT_REL : ST_IDLE;
                    end else if (tick) begin
                        rep_cnt_q <= (rep_cnt_q == RW'(REPEAT_RATE_MS - 1)) ? '0 : rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (&key_db) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign load           = load_q;
    assign load_hour_high = ld_hh_q;
    assign load_hour_low  = ld_hl_q;
    assign load_min_high  = ld_mh_q;
    assign load_min_low   = ld_ml_q;
    assign editing        = editing_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl at CLK_HZ=12000 (12 clk per ms tick).
module tb_clock_set_ctrl;

    localparam int TICK = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hour_a = 1'b1, hour_d = 1'b1, min_a = 1'b1, min_d = 1'b1;
    logic [3:0] cur_hour_high, cur_hour_low, cur_min_high, cur_min_low;
    logic       load, editing;
    logic [3:0] load_hour_high, load_hour_low, load_min_high, load_min_low;

    int checks = 0;
    int errors = 0;

    // Core model: either a fixed preset time, or a time that follows every load.
    logic [15:0] preset = 16'h0000;
    logic [15:0] core_t = 16'h0000;
    logic        follow = 1'b0;
    logic [15:0] cur_t, load_t;
    int          cyc = 0;
    int          load_cnt = 0;
    int          edit_cnt = 0;
    int          load_cyc[$];

    assign cur_t = follow ? core_t : preset;
    assign {cur_hour_high, cur_hour_low, cur_min_high, cur_min_low} = cur_t;
    assign load_t = {load_hour_high, load_hour_low, load_min_high, load_min_low};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!follow) core_t = preset;
        if (load === 1'b1) begin
            load_cnt = load_cnt + 1;
            load_cyc.push_back(cyc);
            if (follow) core_t = load_t;
        end
        if (editing === 1'b1) edit_cnt = edit_cnt + 1;
    end

    clock_set_ctrl #(
        .CLK_HZ(12000), .DEBOUNCE_MS(20), .REPEAT_DELAY_MS(600), .REPEAT_RATE_MS(200)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hour_a(hour_a), .hour_d(hour_d), .min_a(min_a), .min_d(min_d),
        .cur_hour_high(cur_hour_high), .cur_hour_low(cur_hour_low),
        .cur_min_high(cur_min_high), .cur_min_low(cur_min_low),
        .load(load),
        .load_hour_high(load_hour_high), .load_hour_low(load_hour_low),
        .load_min_high(load_min_high), .load_min_low(load_min_low),
        .editing(editing)
    );

    task automatic wait_ms(input int n);
        repeat (n * TICK) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", load); end
        checks++; if (load_t !== 16'h0000) begin errors++; $display("FAIL reset_value got %h want 0000", load_t); end
        checks++; if (editing !== 1'b0) begin errors++; $display("FAIL reset_editing got %b want 0", editing); end
        rst_n = 1'b1;
        wait_ms(2);
    endtask

    task automatic test_hour_wrap;
        int c0, e0;
        preset = 16'h2359; follow = 1'b0;
        wait_ms(1);
        c0 = load_cnt; e0 = edit_cnt;
        hour_a = 1'b0; wait_ms(30); hour_a = 1'b1; wait_ms(40);
        checks++; if (load_cnt - c0 !== 1) begin errors++; $display("FAIL wrap_count got %0d want 1", load_cnt - c0); end
        checks++; if (load_t !== 16'h0059) begin errors++; $display("FAIL wrap_value got %h want 0059", load_t); end
        checks++; if (edit_cnt == e0) begin errors++; $display("FAIL wrap_editing_pulse got none want high"); end
        checks++; if (editing !== 1'b0) begin errors++; $display("FAIL wrap_editing_end got %b want 0", editing); end
    endtask

    task automatic test_min_dec;
        int c0;
        preset = 16'h0000; follow = 1'b0;
        wait_ms(1);
        c0 = load_cnt;
        min_d = 1'b0; wait_ms(30); min_d = 1'b1; wait_ms(40);
        checks++; if (load_cnt - c0 !== 1) begin errors++; $display("FAIL mindec_count got %0d want 1", load_cnt - c0); end
        checks++; if (load_t !== 16'h0059) begin errors++; $display("FAIL mindec_value got %h want 0059", load_t); end
    endtask

    task automatic test_out_of_range;
        int c0;
        preset = 16'h2561; follow = 1'b0;
        wait_ms(1);
        c0 = load_cnt;
        min_a = 1'b0; wait_ms(30); min_a = 1'b1; wait_ms(40);
        checks++; if (load_cnt - c0 !== 1) begin errors++; $display("FAIL oor_count got %0d want 1", load_cnt - c0); end
        checks++; if (load_t !== 16'h0001) begin errors++; $display("FAIL oor_value got %h want 0001", load_t); end
    endtask

    task automatic test_bounce;
        int c0, e0;
        preset = 16'h1234; follow = 1'b0;
        c0 = load_cnt; e0 = edit_cnt;
        for (int i = 0; i < 10; i++) begin
            min_a = ~min_a;
            wait_ms(5);
        end
        min_a = 1'b1;
        wait_ms(40);
        checks++; if (load_cnt != c0) begin errors++; $display("FAIL bounce_loads got %0d want 0", load_cnt - c0); end
        checks++; if (edit_cnt != e0) begin errors++; $display("FAIL bounce_editing got %0d cycles want 0", edit_cnt - e0); end
    endtask

    // Released at 995 ms so the key-up debounce settles before the 1020 ms repeat slot.
    task automatic test_repeat;
        int c0, q0, start, rel;
        int exp_ms[3] = '{20, 620, 820};
        preset = 16'h1000; wait_ms(1); follow = 1'b1; wait_ms(1);
        c0 = load_cnt; q0 = load_cyc.size(); start = cyc;
        hour_a = 1'b0; wait_ms(995); hour_a = 1'b1; wait_ms(60);
        checks++; if (load_cnt - c0 !== 3) begin errors++; $display("FAIL repeat_count got %0d want 3", load_cnt - c0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (load_cyc.size() <= q0 + i) begin
                errors++; $display("FAIL repeat_time%0d got none want %0dms", i, exp_ms[i]);
            end else begin
                rel = load_cyc[q0 + i] - start;
                if (rel < (exp_ms[i] - 2) * TICK || rel > (exp_ms[i] + 2) * TICK) begin
                    errors++; $display("FAIL repeat_time%0d got %0d clk want ~%0d clk", i, rel, exp_ms[i] * TICK);
                end
            end
        end
        checks++; if (load_t !== 16'h1300) begin errors++; $display("FAIL repeat_value got %h want 1300", load_t); end
        checks++; if (core_t !== 16'h1300) begin errors++; $display("FAIL repeat_core got %h want 1300", core_t); end
        follow = 1'b0;
    endtask

    task automatic test_simultaneous;
        int c0;
        preset = 16'h0530; follow = 1'b0;
        wait_ms(1);
        c0 = load_cnt;
        hour_a = 1'b0; min_d = 1'b0; wait_ms(100);
        checks++; if (load_cnt - c0 !== 1) begin errors++; $display("FAIL simul_count got %0d want 1", load_cnt - c0); end
        checks++; if (load_t !== 16'h0630) begin errors++; $display("FAIL simul_value got %h want 0630", load_t); end
        hour_a = 1'b1; wait_ms(700);
        checks++; if (load_cnt - c0 !== 1) begin errors++; $display("FAIL simul_other_held got %0d want 1", load_cnt - c0); end
        min_d = 1'b1; wait_ms(40);
        checks++; if (load_cnt - c0 !== 1) begin errors++; $display("FAIL simul_release got %0d want 1", load_cnt - c0); end
    endtask

    task automatic test_back_to_back;
        int c0;
        preset = 16'h0530; follow = 1'b0;
        c0 = load_cnt;
        min_a = 1'b0; wait_ms(30); min_a = 1'b1; wait_ms(30);
        hour_d = 1'b0; wait_ms(30); hour_d = 1'b1; wait_ms(40);
        checks++; if (load_cnt - c0 !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", load_cnt - c0); end
        checks++; if (load_t !== 16'h0430) begin errors++; $display("FAIL b2b_value got %h want 0430", load_t); end
    endtask

    task automatic test_reset_mid;
        int c0, q0, start, rel;
        preset = 16'h1000; follow = 1'b0;
        hour_a = 1'b0; wait_ms(700);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL rstmid_load got %b want 0", load); end
        checks++; if (load_t !== 16'h0000) begin errors++; $display("FAIL rstmid_value got %h want 0000", load_t); end
        repeat (3) @(negedge clk);
        c0 = load_cnt; q0 = load_cyc.size(); start = cyc;
        rst_n = 1'b1;
        wait_ms(40);
        checks++; if (load_cnt - c0 !== 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", load_cnt - c0); end
        checks++;
        if (load_cyc.size() <= q0) begin
            errors++; $display("FAIL rstmid_time got none want 20ms");
        end else begin
            rel = load_cyc[q0] - start;
            if (rel < 19 * TICK || rel > 22 * TICK) begin
                errors++; $display("FAIL rstmid_time got %0d clk want ~%0d clk", rel, 20 * TICK);
            end
        end
        checks++; if (load_t !== 16'h1100) begin errors++; $display("FAIL rstmid_value2 got %h want 1100", load_t); end
        hour_a = 1'b1; wait_ms(40);
    endtask

    initial begin
        test_reset;
        test_hour_wrap;
        test_min_dec;
        test_out_of_range;
        test_bounce;
        test_repeat;
        test_simultaneous;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
